// File: rtl/csr_unit_pkg.sv
// Shared CSR addresses, op encodings, mstatus layout and read/decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package csr_unit_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_RW   = 2'b00,
        CSR_OP_RS   = 2'b01,
        CSR_OP_RC   = 2'b10,
        CSR_OP_RSVD = 2'b11
    } csr_op_e;

    // mstatus layout: MIE/MPIE are the only writable bits, MPP is hardwired to M-mode
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam logic [31:0] MSTATUS_FIXED    = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK        = 32'h0000_0888;

    // Snapshot of every architecturally visible CSR, already in read format
    typedef struct packed {
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mip;
        logic [31:0] mcycle;
        logic [31:0] mcycleh;
        logic [31:0] minstret;
        logic [31:0] minstreth;
        logic [31:0] mhartid;
    } csr_state_t;

    function automatic logic csr_known(input logic [11:0] a);
        logic r;
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MCYCLEH, CSR_MINSTRETH, CSR_MHARTID: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic csr_readonly(input logic [11:0] a);
        return (a == CSR_MIP) || (a == CSR_MHARTID);
    endfunction

    function automatic logic [31:0] csr_read(input csr_state_t s, input logic [11:0] a);
        logic [31:0] r;
        case (a)
            CSR_MSTATUS:   r = s.mstatus;
            CSR_MIE:       r = s.mie;
            CSR_MTVEC:     r = s.mtvec;
            CSR_MSCRATCH:  r = s.mscratch;
            CSR_MEPC:      r = s.mepc;
            CSR_MCAUSE:    r = s.mcause;
            CSR_MTVAL:     r = s.mtval;
            CSR_MIP:       r = s.mip;
            CSR_MCYCLE:    r = s.mcycle;
            CSR_MCYCLEH:   r = s.mcycleh;
            CSR_MINSTRET:  r = s.minstret;
            CSR_MINSTRETH: r = s.minstreth;
            CSR_MHARTID:   r = s.mhartid;
            default:       r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] r;
        r = MSTATUS_FIXED;
        r[MSTATUS_MIE_BIT]  = mie;
        r[MSTATUS_MPIE_BIT] = mpie;
        return r;
    endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// CNT_WIDTH-bit free-running counter with independent 32-bit low/high half writes.
// Latency: write or increment visible 1 cycle later; a write to either half suppresses that cycle's increment.
// Backpressure: none. Ports: i_inc, i_wr_lo, i_wr_hi, i_wdata -> o_cnt.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_wr_lo,
    input  logic                 i_wr_hi,
    input  logic [31:0]          i_wdata,
    output logic [CNT_WIDTH-1:0] o_cnt
);
    localparam int HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_cnt[31:0]           <= i_wdata;
            if (i_wr_hi) r_cnt[CNT_WIDTH-1:32] <= i_wdata[HI_W-1:0];
        end else if (i_inc) begin
            // wraps from all-ones to zero silently
            r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: RW/RS/RC writes with WARL masking, atomic trap/mret updates, counters, synchronised mip.
// Latency: reads combinational (with same-cycle write bypass); writes/trap/mret commit on the next clk edge; mip lags irq lines by 2 cycles.
// Backpressure: none; every cycle is accepted. Priority trap_valid > mret_valid > csr_we per register.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter bit          VECTORED_EN = 1'b0,
    parameter bit          CNT_EN      = 1'b1,
    parameter int          CNT_WIDTH   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wsrc,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instr_retire,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    output logic [31:0] csr_mtvec,
    output logic [31:0] csr_mepc,
    output logic [31:0] csr_mstatus,
    output logic        global_interrupt_enable,
    output logic        irq_pending
);
    // Bits of the counter high half that actually exist; zero when counters are absent
    localparam logic [63:0] CNT_MASK = (CNT_WIDTH >= 64) ? {64{1'b1}}
                                     : ((64'd1 << CNT_WIDTH) - 64'd1);
    localparam logic [31:0] HI_MASK  = CNT_EN ? CNT_MASK[63:32] : 32'h0;
    localparam logic [31:0] LO_MASK  = CNT_EN ? 32'hFFFF_FFFF   : 32'h0;

    logic        r_mie_bit;
    logic        r_mpie_bit;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [2:0]  r_irq_s1;   // {external, timer, software}
    logic [2:0]  r_irq_s2;

    logic [CNT_WIDTH-1:0] w_cyc;
    logic [CNT_WIDTH-1:0] w_ins;
    logic [63:0]          w_cyc64;
    logic [63:0]          w_ins64;
    logic [31:0]          w_mip;
    csr_state_t           w_st;
    csr_op_e              w_op;
    logic [31:0]          w_old;
    logic [31:0]          w_new;
    logic [31:0]          w_new_masked;
    logic                 w_wr_legal;
    logic                 w_wr_en;

    assign w_cyc64 = 64'(w_cyc);
    assign w_ins64 = 64'(w_ins);
    assign w_mip   = {20'h0, r_irq_s2[2], 3'b000, r_irq_s2[1], 3'b000, r_irq_s2[0], 3'b000};

    always_comb begin
        w_st           = '0;
        w_st.mstatus   = mstatus_pack(r_mie_bit, r_mpie_bit);
        w_st.mie       = r_mie;
        w_st.mtvec     = r_mtvec;
        w_st.mscratch  = r_mscratch;
        w_st.mepc      = r_mepc;
        w_st.mcause    = r_mcause;
        w_st.mtval     = r_mtval;
        w_st.mip       = w_mip;
        w_st.mcycle    = w_cyc64[31:0];
        w_st.mcycleh   = w_cyc64[63:32];
        w_st.minstret  = w_ins64[31:0];
        w_st.minstreth = w_ins64[63:32];
        w_st.mhartid   = HART_ID;
    end

    // Write datapath: read-modify-write on the stored value at csr_waddr
    assign w_op       = csr_op_e'(csr_op);
    assign w_old      = csr_read(w_st, csr_waddr);
    assign w_wr_legal = csr_known(csr_waddr) && !csr_readonly(csr_waddr);
    assign w_wr_en    = csr_we && w_wr_legal && (w_op != CSR_OP_RSVD);

    always_comb begin
        w_new = w_old;
        case (w_op)
            CSR_OP_RW: w_new = csr_wsrc;
            CSR_OP_RS: w_new = w_old | csr_wsrc;
            CSR_OP_RC: w_new = w_old & ~csr_wsrc;
            default:   w_new = w_old;
        endcase
    end

    always_comb begin
        w_new_masked = w_new;
        case (csr_waddr)
            CSR_MSTATUS:                w_new_masked = MSTATUS_FIXED | (w_new & MSTATUS_WMASK);
            CSR_MIE:                    w_new_masked = w_new & MIE_WMASK;
            CSR_MTVEC:                  w_new_masked = {w_new[31:2],
                                                        (VECTORED_EN && (w_new[1:0] == 2'b01)) ? 2'b01 : 2'b00};
            CSR_MEPC:                   w_new_masked = {w_new[31:2], 2'b00};
            CSR_MCYCLE, CSR_MINSTRET:   w_new_masked = w_new & LO_MASK;
            CSR_MCYCLEH, CSR_MINSTRETH: w_new_masked = w_new & HI_MASK;
            default:                    w_new_masked = w_new;
        endcase
    end

    // Same-cycle read of the register being written returns the value it will hold
    assign csr_rdata   = (csr_we && w_wr_legal && (csr_raddr == csr_waddr)) ? w_new_masked
                                                                            : csr_read(w_st, csr_raddr);
    assign csr_illegal = csr_we && !w_wr_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_bit  <= 1'b0;
            r_mpie_bit <= 1'b0;
            r_mie      <= 32'h0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
            r_irq_s1   <= 3'b000;
            r_irq_s2   <= 3'b000;
        end else begin
            r_irq_s1 <= {irq_external, irq_timer, irq_software};
            r_irq_s2 <= r_irq_s1;

            // Registers untouched by trap/mret always take software writes
            if (w_wr_en && (csr_waddr == CSR_MIE))      r_mie      <= w_new_masked;
            if (w_wr_en && (csr_waddr == CSR_MTVEC))    r_mtvec    <= w_new_masked;
            if (w_wr_en && (csr_waddr == CSR_MSCRATCH)) r_mscratch <= w_new_masked;

            if (trap_valid) begin
                r_mepc     <= {trap_pc[31:2], 2'b00};
                r_mcause   <= trap_cause;
                r_mtval    <= trap_tval;
                r_mpie_bit <= r_mie_bit;
                r_mie_bit  <= 1'b0;
            end else begin
                if (mret_valid) begin
                    r_mie_bit  <= r_mpie_bit;
                    r_mpie_bit <= 1'b1;
                end else if (w_wr_en && (csr_waddr == CSR_MSTATUS)) begin
                    r_mie_bit  <= w_new_masked[MSTATUS_MIE_BIT];
                    r_mpie_bit <= w_new_masked[MSTATUS_MPIE_BIT];
                end
                if (w_wr_en && (csr_waddr == CSR_MEPC))   r_mepc   <= w_new_masked;
                if (w_wr_en && (csr_waddr == CSR_MCAUSE)) r_mcause <= w_new_masked;
                if (w_wr_en && (csr_waddr == CSR_MTVAL))  r_mtval  <= w_new_masked;
            end
        end
    end

    generate
        if (CNT_EN) begin : g_cnt
            csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_inc   (1'b1),
                .i_wr_lo (w_wr_en && (csr_waddr == CSR_MCYCLE)),
                .i_wr_hi (w_wr_en && (csr_waddr == CSR_MCYCLEH)),
                .i_wdata (w_new_masked),
                .o_cnt   (w_cyc)
            );
            csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_inc   (instr_retire),
                .i_wr_lo (w_wr_en && (csr_waddr == CSR_MINSTRET)),
                .i_wr_hi (w_wr_en && (csr_waddr == CSR_MINSTRETH)),
                .i_wdata (w_new_masked),
                .o_cnt   (w_ins)
            );
        end else begin : g_no_cnt
            assign w_cyc = '0;
            assign w_ins = '0;
        end
    endgenerate

    assign csr_mtvec               = r_mtvec;
    assign csr_mepc                = r_mepc;
    assign csr_mstatus             = w_st.mstatus;
    assign global_interrupt_enable = r_mie_bit;
    assign irq_pending             = r_mie_bit && |(r_mie & w_mip);

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
// Latency: inputs driven 1ns after posedge, outputs sampled after 1ns settle.
// Backpressure: n/a.
module tb_csr_unit;
    import csr_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wsrc;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        instr_retire;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;
    logic        global_interrupt_enable;
    logic        irq_pending;

    int errors = 0;
    int checks = 0;

    csr_unit #(
        .HART_ID     (32'd3),
        .MTVEC_RESET (32'h0000_0100),
        .VECTORED_EN (1'b0),
        .CNT_EN      (1'b1),
        .CNT_WIDTH   (64)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .csr_raddr               (csr_raddr),
        .csr_rdata               (csr_rdata),
        .csr_we                  (csr_we),
        .csr_op                  (csr_op),
        .csr_waddr               (csr_waddr),
        .csr_wsrc                (csr_wsrc),
        .csr_illegal             (csr_illegal),
        .trap_valid              (trap_valid),
        .trap_cause              (trap_cause),
        .trap_pc                 (trap_pc),
        .trap_tval               (trap_tval),
        .mret_valid              (mret_valid),
        .instr_retire            (instr_retire),
        .irq_software            (irq_software),
        .irq_timer               (irq_timer),
        .irq_external            (irq_external),
        .csr_mtvec               (csr_mtvec),
        .csr_mepc                (csr_mepc),
        .csr_mstatus             (csr_mstatus),
        .global_interrupt_enable (global_interrupt_enable),
        .irq_pending             (irq_pending)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_op    = op;
        csr_waddr = a;
        csr_wsrc  = d;
        tick(1);
        csr_we    = 1'b0;
        csr_op    = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        csr_raddr = 12'h0; csr_we = 1'b0; csr_op = 2'b00; csr_waddr = 12'h0; csr_wsrc = 32'h0;
        trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
        mret_valid = 1'b0; instr_retire = 1'b0;
        irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0;
        #25 rst_n = 1'b1;
        tick(1);

        // Reset state
        rchk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rchk("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
        chk("rst_mstatus_port", csr_mstatus, 32'h0000_1800);
        chk("rst_mtvec_port", csr_mtvec, 32'h0000_0100);
        chk("rst_irq_pending", {31'h0, irq_pending}, 32'h0);
        chk("rst_gie", {31'h0, global_interrupt_enable}, 32'h0);
        rchk("rst_mhartid", CSR_MHARTID, 32'd3);
        csr_raddr = CSR_MSTATUS;
        #1;
        chk("rst_illegal", {31'h0, csr_illegal}, 32'h0);

        // WARL on mstatus and set/clear on mie
        wr(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
        rchk("mstatus_warl", CSR_MSTATUS, 32'h0000_1888);
        chk("gie_set", {31'h0, global_interrupt_enable}, 32'h1);
        wr(CSR_OP_RS, CSR_MIE, 32'h0000_0888);
        rchk("mie_rs", CSR_MIE, 32'h0000_0888);
        csr_we = 1'b1; csr_op = CSR_OP_RC; csr_waddr = CSR_MIE; csr_wsrc = 32'h0000_0080;
        rchk("mie_rc_bypass", CSR_MIE, 32'h0000_0808);
        tick(1);
        csr_we = 1'b0; csr_op = 2'b00;
        rchk("mie_rc", CSR_MIE, 32'h0000_0808);
        wr(CSR_OP_RW, CSR_MIE, 32'h0000_0080);

        // Timer interrupt through the synchroniser
        irq_timer = 1'b1;
        #1;
        chk("irq_n0_pending", {31'h0, irq_pending}, 32'h0);
        tick(1);
        rchk("irq_n1_mip", CSR_MIP, 32'h0);
        chk("irq_n1_pending", {31'h0, irq_pending}, 32'h0);
        tick(1);
        rchk("irq_n2_mip", CSR_MIP, 32'h0000_0080);
        chk("irq_n2_pending", {31'h0, irq_pending}, 32'h1);
        irq_timer = 1'b0;
        tick(1);
        chk("irq_fall1_pending", {31'h0, irq_pending}, 32'h1);
        tick(1);
        chk("irq_fall2_pending", {31'h0, irq_pending}, 32'h0);
        rchk("irq_fall2_mip", CSR_MIP, 32'h0);

        // Software irq pending in mip but not enabled in mie
        irq_software = 1'b1;
        tick(2);
        rchk("msip_mip", CSR_MIP, 32'h0000_0008);
        chk("msip_masked", {31'h0, irq_pending}, 32'h0);
        irq_software = 1'b0;
        tick(2);

        // mtvec / mepc WARL
        wr(CSR_OP_RW, CSR_MTVEC, 32'h0000_2001);
        rchk("mtvec_mode", CSR_MTVEC, 32'h0000_2000);
        wr(CSR_OP_RW, CSR_MEPC, 32'h0000_0123);
        rchk("mepc_align", CSR_MEPC, 32'h0000_0120);

        // Trap entry beats a same-cycle mepc write
        trap_valid = 1'b1; trap_pc = 32'h0000_1002; trap_cause = 32'h8000_0007; trap_tval = 32'hDEAD_BEEF;
        csr_we = 1'b1; csr_op = CSR_OP_RW; csr_waddr = CSR_MEPC; csr_wsrc = 32'h0000_0040;
        tick(1);
        trap_valid = 1'b0; csr_we = 1'b0;
        chk("trap_mepc", csr_mepc, 32'h0000_1000);
        rchk("trap_mcause", CSR_MCAUSE, 32'h8000_0007);
        rchk("trap_mtval", CSR_MTVAL, 32'hDEAD_BEEF);
        rchk("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
        chk("trap_gie", {31'h0, global_interrupt_enable}, 32'h0);

        // mret beats a same-cycle mstatus write
        mret_valid = 1'b1;
        csr_we = 1'b1; csr_op = CSR_OP_RW; csr_waddr = CSR_MSTATUS; csr_wsrc = 32'h0;
        tick(1);
        mret_valid = 1'b0; csr_we = 1'b0;
        rchk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

        // Trap with an unrelated write: mscratch still commits
        trap_valid = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'h0000_000B; trap_tval = 32'h0;
        csr_we = 1'b1; csr_op = CSR_OP_RW; csr_waddr = CSR_MSCRATCH; csr_wsrc = 32'h0000_1234;
        tick(1);
        trap_valid = 1'b0; csr_we = 1'b0;
        rchk("trap2_mscratch", CSR_MSCRATCH, 32'h0000_1234);
        rchk("trap2_mepc", CSR_MEPC, 32'h0000_2000);
        mret_valid = 1'b1;
        tick(1);
        mret_valid = 1'b0;
        rchk("mret2_mstatus", CSR_MSTATUS, 32'h0000_1888);

        // mcycle carry into the high half
        wr(CSR_OP_RW, CSR_MCYCLEH, 32'h0);
        wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFE);
        rchk("mcycle_wr", CSR_MCYCLE, 32'hFFFF_FFFE);
        rchk("mcycleh_wr", CSR_MCYCLEH, 32'h0);
        tick(1);
        rchk("mcycle_c1", CSR_MCYCLE, 32'hFFFF_FFFF);
        tick(1);
        rchk("mcycle_c2", CSR_MCYCLE, 32'h0);
        rchk("mcycleh_c2", CSR_MCYCLEH, 32'h1);

        // minstret counts retire cycles only
        wr(CSR_OP_RW, CSR_MINSTRETH, 32'h0);
        wr(CSR_OP_RW, CSR_MINSTRET, 32'h0);
        instr_retire = 1'b1;
        tick(3);
        instr_retire = 1'b0;
        tick(2);
        instr_retire = 1'b1;
        tick(1);
        instr_retire = 1'b0;
        rchk("minstret", CSR_MINSTRET, 32'd4);
        rchk("minstreth", CSR_MINSTRETH, 32'h0);

        // Illegal writes and reserved op
        csr_we = 1'b1; csr_op = CSR_OP_RW; csr_waddr = CSR_MHARTID; csr_wsrc = 32'hFFFF_FFFF;
        #1;
        chk("ill_mhartid", {31'h0, csr_illegal}, 32'h1);
        tick(1);
        csr_waddr = 12'h7C0;
        #1;
        chk("ill_unknown", {31'h0, csr_illegal}, 32'h1);
        rchk("unknown_read", 12'h7C0, 32'h0);
        tick(1);
        csr_waddr = CSR_MIP;
        #1;
        chk("ill_mip", {31'h0, csr_illegal}, 32'h1);
        tick(1);
        csr_op = CSR_OP_RSVD; csr_waddr = CSR_MIE; csr_wsrc = 32'h0;
        #1;
        chk("rsvd_legal", {31'h0, csr_illegal}, 32'h0);
        tick(1);
        csr_we = 1'b0; csr_op = 2'b00;
        rchk("ill_hartid_keep", CSR_MHARTID, 32'd3);
        rchk("ill_mip_keep", CSR_MIP, 32'h0);
        rchk("rsvd_mie_keep", CSR_MIE, 32'h0000_0080);
        rchk("ill_mstatus_keep", CSR_MSTATUS, 32'h0000_1888);

        // Asynchronous reset mid-stream, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mstatus", csr_mstatus, 32'h0000_1800);
        chk("arst_mtvec", csr_mtvec, 32'h0000_0100);
        chk("arst_mepc", csr_mepc, 32'h0);
        chk("arst_gie", {31'h0, global_interrupt_enable}, 32'h0);
        chk("arst_pending", {31'h0, irq_pending}, 32'h0);
        rchk("arst_mie", CSR_MIE, 32'h0);
        rchk("arst_mscratch", CSR_MSCRATCH, 32'h0);
        rchk("arst_mcause", CSR_MCAUSE, 32'h0);
        rchk("arst_mtval", CSR_MTVAL, 32'h0);
        rchk("arst_mcycleh", CSR_MCYCLEH, 32'h0);
        rchk("arst_minstret", CSR_MINSTRET, 32'h0);
        #20 rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR file, successor to the existing single-write-port CSR block.
- Sits between id_stage (read), ex_stage (CSRRW/RS/RC execution) and clint (trap entry and mret).
- Adds atomic trap/mret updates, set/clear ops, WARL masking, 64-bit cycle/instret counters, hardware-driven mip and a pending-interrupt output.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0, reset value of mtvec.
- VECTORED_EN, 0, 1 allows mtvec.MODE=01; 0 forces MODE=00.
- CNT_EN, 1, 1 instantiates mcycle/minstret; 0 makes them read 0.
- CNT_WIDTH, 64, counter width, 33..64; upper bits above CNT_WIDTH read 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csr_raddr  in  12  read address from id_stage
- csr_rdata  out  32  read data, combinational
- csr_we  in  1  ex_stage CSR write strobe
- csr_op  in  2  00 RW, 01 RS, 10 RC, 11 reserved (no write)
- csr_waddr  in  12  ex_stage write address
- csr_wsrc  in  32  operand (rs1 or zimm)
- csr_illegal  out  1  unknown address, or write to a read-only CSR (combinational, on waddr when csr_we)
- trap_valid  in  1  clint trap entry
- trap_cause  in  32  mcause value
- trap_pc  in  32  mepc value
- trap_tval  in  32  mtval value
- mret_valid  in  1  clint mret commit
- instr_retire  in  1  one instruction retired this cycle
- irq_software  in  1  level, maps to mip.MSIP (bit 3)
- irq_timer  in  1  level, maps to mip.MTIP (bit 7)
- irq_external  in  1  level, maps to mip.MEIP (bit 11)
- csr_mtvec  out  32  current mtvec
- csr_mepc  out  32  current mepc
- csr_mstatus  out  32  current mstatus
- global_interrupt_enable  out  1  mstatus.MIE
- irq_pending  out  1  |(mie & mip) & mstatus.MIE

Behaviour:
- Reset (async, rst_n low):
  - mstatus = 32'h0000_1800 (MPP=11).
  - mie = 0, mepc = 0, mcause = 0, mtval = 0, mscratch = 0, mtvec = MTVEC_RESET.
  - Counters = 0, mip sync flops = 0.
  - Outputs follow these values; irq_pending = 0.
- Write data: old = stored value at csr_waddr.
  - RW: new = wsrc. RS: new = old | wsrc. RC: new = old & ~wsrc. op=11 writes nothing.
  - The RTL performs RS/RC with wsrc=0 as a normal write.
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP reads 11.
  - mie: bits 3, 7, 11 writable.
  - mtvec: MODE=01 kept only if VECTORED_EN, else [1:0]=00.
  - mepc: [1:0]=0.
  - mip and mhartid are read-only; writes are ignored and flag csr_illegal.
- Read bypass: csr_we && csr_raddr==csr_waddr && legal returns the masked new value; otherwise the stored value. Unknown addresses read 0.
- mip: each irq_* line passes through a 2-flop synchroniser, so mip reflects the line 2 cycles after it changes; irq_pending is valid the same cycle mip updates.
- Trap entry (trap_valid) in one cycle:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_tval.
  - MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- Priority per cycle: trap_valid > mret_valid > csr_we. A lower-priority update to the same register is dropped; a csr_we to an unrelated register still commits.
- Counters: mcycle increments every cycle; minstret increments when instr_retire.
  - Low/high halves at 0xB00/0xB80 and 0xB02/0xB82.
  - A software write to a half replaces that half and suppresses that counter's increment this cycle.
  - Wrap from all-ones to 0, no flag.
- Reset asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- defines.v gains CSR_MSCRATCH 12'h340, CSR_MCYCLE 12'hB00, CSR_MINSTRET 12'hB02, CSR_MCYCLEH 12'hB80, CSR_MINSTRETH 12'hB82, CSR_MHARTID 12'hF14, csr_op encodings, and mstatus bit indices.
- Sub-module csr_counter: CNT_WIDTH counter with inc, and write-low/write-high ports, instantiated twice.

Test Plan:
- Reset, then read mstatus/mtvec -> 32'h1800 / MTVEC_RESET; irq_pending=0; csr_illegal=0 for csr_raddr=0x300.
- RW mstatus 0xFFFF_FFFF -> reads 32'h0000_1888. RS mie 0x888, then RC 0x080 -> mie=32'h808. Same-cycle read of mie during the RC returns 32'h808.
- Set MIE=1 and mie=0x080; raise irq_timer at cycle N -> mip[7]=1 and irq_pending=1 at cycle N+2; deassert -> 0 two cycles later.
- trap_valid with pc=0x1002, cause=0x8000_0007 while csr_we writes mepc=0x40 -> mepc=0x1000, MIE=0, MPIE=1. Next cycle mret -> MIE=1, MPIE=1.
- Write mcycle low=0xFFFF_FFFE, high=0 -> after 2 cycles mcycleh=1, mcycle low=0. minstret counts only cycles with instr_retire=1.
- Write 0xF14 or an unknown address 0x7C0 -> csr_illegal=1; no state changes; rst_n pulsed low mid-stream -> all CSRs at reset values before the next clk edge.
